// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam logic [KP_COLS-1:0] COL_IDLE = 4'b1110;

    // One-hot-low column drive for a column index.
    function automatic logic [KP_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Index of the lowest-numbered active-low row.
    function automatic logic [1:0] lowest_low(input logic [KP_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KP_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_div.sv
// Free-running divider producing a one-clock scan tick every CLK_DIV clocks.
module tick_div #(
    parameter int unsigned CLK_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    // Tick is registered one count early so it lines up with r_div == CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
            r_tick <= (r_div == DIV_W'(CLK_DIV - 2));
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row synchronizer, press/release debounce FSM.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 25000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_ROWS-1:0] row_in,
    output logic [KP_COLS-1:0] col_out,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_held
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic               w_tick;
    logic               w_row_low;
    logic [KP_ROWS-1:0] r_sync1;
    logic [KP_ROWS-1:0] r_rows_s;
    kp_state_e          r_state;
    logic [1:0]         r_col_idx;
    logic [1:0]         r_row_idx;
    logic [CNT_W-1:0]   r_count;
    logic [KP_COLS-1:0] r_col_out;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_held;

    tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_row_low = ~r_rows_s[r_row_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= '1;
            r_rows_s    <= '1;
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_count     <= '0;
            r_col_out   <= COL_IDLE;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_sync1     <= row_in;
            r_rows_s    <= r_sync1;
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (r_rows_s == 4'hF) begin
                            r_col_idx <= r_col_idx + 2'd1;
                            r_col_out <= col_drive(r_col_idx + 2'd1);
                        end else begin
                            r_row_idx <= lowest_low(r_rows_s);
                            if (DEBOUNCE_TICKS == 1) begin
                                r_key_code  <= {lowest_low(r_rows_s), r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_count     <= '0;
                                r_state     <= HELD;
                            end else begin
                                r_count <= CNT_W'(1);
                                r_state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!w_row_low) begin
                            r_count <= '0;
                            r_state <= SCAN;
                        end else if (r_count == CNT_LAST) begin
                            r_key_code  <= {r_row_idx, r_col_idx};
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_count     <= '0;
                            r_state     <= HELD;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!w_row_low) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                r_key_held <= 1'b0;
                                r_count    <= '0;
                                r_state    <= SCAN;
                            end else begin
                                r_count <= CNT_W'(1);
                                r_state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        // A re-press during release debounce returns to HELD silently.
                        if (w_row_low) begin
                            r_count <= '0;
                            r_state <= HELD;
                        end else if (r_count == CNT_LAST) begin
                            r_key_held <= 1'b0;
                            r_count    <= '0;
                            r_state    <= SCAN;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign col_out   = r_col_out;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench: physical keypad model driving rows from col_out, plus a run-length reference model.
module tb_keypad_scan;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEB     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0;   // keys[r*4+c] = key at row r, column c is pressed

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scanned column, tracked row (-1 = none), run length of matching samples.
    int         m_col;
    int         m_row;
    int         m_run;
    bit         m_held;
    logic [3:0] m_code;
    int         m_pulses = 0;
    int         d_pulses = 0;

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col_out[c] === 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) row_in[r] = 1'b0;
                end
            end
        end
    end

    keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic model_reset();
        m_col  = 0;
        m_row  = -1;
        m_run  = 0;
        m_held = 0;
        m_code = 4'h0;
    endtask

    task automatic model_tick(output bit accepted);
        int low;
        accepted = 0;
        if (!m_held) begin
            if (m_row < 0) begin
                low = -1;
                for (int r = 3; r >= 0; r--) if (keys[r*4+m_col]) low = r;
                if (low < 0) m_col = (m_col + 1) % 4;
                else begin
                    m_row = low;
                    m_run = 1;
                end
            end else if (keys[m_row*4+m_col]) begin
                m_run++;
            end else begin
                m_row = -1;
                m_run = 0;
            end
            if (m_row >= 0 && m_run == DEB) begin
                m_code   = 4'(m_row * 4 + m_col);
                m_held   = 1;
                m_run    = 0;
                accepted = 1;
            end
        end else begin
            if (keys[m_row*4+m_col]) m_run = 0;
            else m_run++;
            if (m_run == DEB) begin
                m_held = 0;
                m_row  = -1;
                m_run  = 0;
            end
        end
    endtask

    // Advance one scan tick (CLK_DIV clocks), checking outputs after every clock.
    task automatic run_tick(input string tag);
        bit         ev;
        logic [3:0] exp_col;
        for (int e = 0; e < int'(CLK_DIV); e++) begin
            @(posedge clk);
            #1;
            ev = 0;
            if (e == int'(CLK_DIV) - 1) model_tick(ev);
            if (key_valid === 1'b1) d_pulses++;
            if (ev) m_pulses++;
            exp_col = ~(4'b0001 << m_col);
            n_cmp++;
            if (key_valid !== ev) begin
                n_bad++;
                $display("FAIL %s key_valid t=%0t got %b exp %b", tag, $time, key_valid, ev);
            end
            n_cmp++;
            if (col_out !== exp_col) begin
                n_bad++;
                $display("FAIL %s col_out t=%0t got %b exp %b", tag, $time, col_out, exp_col);
            end
            n_cmp++;
            if (key_code !== m_code) begin
                n_bad++;
                $display("FAIL %s key_code t=%0t got %h exp %h", tag, $time, key_code, m_code);
            end
            n_cmp++;
            if (key_held !== m_held) begin
                n_bad++;
                $display("FAIL %s key_held t=%0t got %b exp %b", tag, $time, key_held, m_held);
            end
        end
    endtask

    task automatic test_reset();
        keys  = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (col_out !== 4'b1110) begin n_bad++; $display("FAIL reset col_out got %b exp 1110", col_out); end
        n_cmp++;
        if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset key_code got %h exp 0", key_code); end
        n_cmp++;
        if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset key_valid got %b exp 0", key_valid); end
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset key_held got %b exp 0", key_held); end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        for (int t = 0; t < 4; t++) begin
            run_tick("scan");
            n_cmp++;
            if (col_out !== seq[t]) begin
                n_bad++;
                $display("FAIL scan_seq step %0d got %b exp %b", t, col_out, seq[t]);
            end
        end
        repeat (4) run_tick("scan");
    endtask

    task automatic test_press();
        int d0;
        d0 = d_pulses;
        keys = 16'h0;
        keys[2*4+1] = 1'b1;
        repeat (10) run_tick("press");
        n_cmp++;
        if (d_pulses - d0 !== 1) begin n_bad++; $display("FAIL press pulses got %0d exp 1", d_pulses - d0); end
        n_cmp++;
        if (key_code !== 4'h9) begin n_bad++; $display("FAIL press key_code got %h exp 9", key_code); end
        n_cmp++;
        if (key_held !== 1'b1) begin n_bad++; $display("FAIL press key_held got %b exp 1", key_held); end
        n_cmp++;
        if (col_out !== 4'b1101) begin n_bad++; $display("FAIL press col_out got %b exp 1101", col_out); end
    endtask

    task automatic test_release_glitch();
        int d0;
        d0 = d_pulses;
        keys = 16'h0;
        run_tick("glitch");
        keys[2*4+1] = 1'b1;
        run_tick("glitch");
        keys = 16'h0;
        run_tick("glitch");
        run_tick("glitch");
        n_cmp++;
        if (key_held !== 1'b1) begin n_bad++; $display("FAIL glitch held_2nd got %b exp 1", key_held); end
        run_tick("glitch");
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL glitch held_3rd got %b exp 0", key_held); end
        n_cmp++;
        if (d_pulses !== d0) begin n_bad++; $display("FAIL glitch pulses got %0d exp %0d", d_pulses, d0); end
    endtask

    task automatic test_bounce();
        int  d0;
        bit  seen;
        d0   = d_pulses;
        seen = 0;
        keys = 16'h0;
        keys[2*4+1] = 1'b1;
        for (int t = 0; t < 8 && !seen; t++) begin
            run_tick("bounce");
            if (m_row >= 0) seen = 1;
        end
        n_cmp++;
        if (!seen || m_col != 1) begin n_bad++; $display("FAIL bounce capture got row %0d col %0d exp row 2 col 1", m_row, m_col); end
        run_tick("bounce");
        keys = 16'h0;
        run_tick("bounce");
        run_tick("bounce");
        n_cmp++;
        if (col_out !== 4'b1011) begin n_bad++; $display("FAIL bounce col_out got %b exp 1011", col_out); end
        n_cmp++;
        if (key_code !== 4'h9) begin n_bad++; $display("FAIL bounce key_code got %h exp 9", key_code); end
        n_cmp++;
        if (d_pulses !== d0) begin n_bad++; $display("FAIL bounce pulses got %0d exp %0d", d_pulses, d0); end
    endtask

    task automatic test_two_rows();
        int d0;
        d0 = d_pulses;
        keys = 16'h0;
        keys[1*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        for (int t = 0; t < 12 && !m_held; t++) run_tick("tworow");
        run_tick("tworow");
        n_cmp++;
        if (key_code !== 4'h7) begin n_bad++; $display("FAIL tworow key_code got %h exp 7", key_code); end
        n_cmp++;
        if (d_pulses - d0 !== 1) begin n_bad++; $display("FAIL tworow pulses got %0d exp 1", d_pulses - d0); end
        keys = 16'h0;
        repeat (DEB + 2) run_tick("tworow");
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL tworow key_held got %b exp 0", key_held); end
    endtask

    task automatic test_reset_mid();
        int d0;
        keys = 16'h0;
        keys[2*4+1] = 1'b1;
        for (int t = 0; t < 8 && m_row < 0; t++) run_tick("rstmid");
        run_tick("rstmid");
        n_cmp++;
        if (m_run != 2) begin n_bad++; $display("FAIL rstmid setup run got %0d exp 2", m_run); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (col_out !== 4'b1110) begin n_bad++; $display("FAIL rstmid col_out got %b exp 1110", col_out); end
        n_cmp++;
        if ({key_code, key_valid, key_held} !== 6'b0) begin
            n_bad++;
            $display("FAIL rstmid outputs got code %h valid %b held %b exp 0", key_code, key_valid, key_held);
        end
        keys  = 16'h0;
        rst_n = 1'b1;
        d0 = d_pulses;
        repeat (6) run_tick("rstmid");
        n_cmp++;
        if (d_pulses !== d0) begin n_bad++; $display("FAIL rstmid pulses got %0d exp %0d", d_pulses, d0); end
    endtask

    task automatic test_random();
        int sel;
        keys = 16'h0;
        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       keys = 16'h0;
                1:       keys = 16'(1) << $urandom_range(0, 15);
                2:       keys[$urandom_range(0, 15)] = 1'b1;
                default: ;
            endcase
            run_tick("random");
        end
        n_cmp++;
        if (d_pulses !== m_pulses) begin n_bad++; $display("FAIL random pulse_total got %0d exp %0d", d_pulses, m_pulses); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_release_glitch();
        test_bounce();
        test_two_rows();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner; the input-side counterpart of the multiplexed 8-digit seven-segment display driver.
- Drives columns one at a time (active-low) and samples the rows.
- Debounces both press and release.
- On a stable press, reports a 4-bit key code with a one-cycle valid pulse.
- Sits between board I/O pins and the CPU-side input register.

Parameters:
- CLK_DIV, 25000: system clocks per scan tick (1 ms-class tick); minimum 4.
- DEBOUNCE_TICKS, 20: consecutive matching sample ticks required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- row_in  input  4  keypad rows; active-low (pulled up), asynchronous to clk.
- col_out  output  4  column drive; exactly one bit low while scanning, one-hot-low.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key; held until the next accept.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from accept until release is accepted.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - col_out=4'b1110, key_code=0, key_valid=0, key_held=0.
  - state=SCAN; divider, debounce counter and synchronizer all cleared (synchronizer flops reset to 1).
- row_in passes through a 2-flop synchronizer; all sampling uses the synchronized value (rows_s).
- Tick generation:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - tick is high for one clk when divider==CLK_DIV-1.
  - All FSM actions below happen only on tick cycles, except that key_valid deasserts on the cycle after it rises.
- Column index col_idx 0..3; col_out = ~(1<<col_idx).
- SCAN:
  - On tick with rows_s==4'hF: col_idx increments mod 4 (wraps 3->0).
  - On tick with any rows_s bit low: capture row_idx = lowest-index low bit; freeze col_idx; count=1; go DEBOUNCE.
  - If DEBOUNCE_TICKS==1, accept immediately instead (same rules as the accept step in DEBOUNCE).
- DEBOUNCE:
  - On tick, if rows_s[row_idx]==0: count+1.
  - When count reaches DEBOUNCE_TICKS: key_code={row_idx,col_idx}, key_valid=1 for exactly the next clk, key_held=1; go HELD.
  - On tick, if rows_s[row_idx]==1: count=0; go SCAN. col_idx resumes advancing on the next tick; no pulse.
- HELD:
  - col_out stays frozen.
  - On tick with rows_s[row_idx]==1: count=1; go RELEASE.
- RELEASE:
  - On tick with rows_s[row_idx]==1: count+1.
  - At DEBOUNCE_TICKS: key_held=0, count=0; go SCAN. col_idx advances on the following tick.
  - On tick with rows_s[row_idx]==0: count=0; back to HELD. No new key_valid; key_held stays 1.
- Other rows changing while in DEBOUNCE, HELD or RELEASE are ignored; only the captured row is tracked.
- Simultaneous low rows in the scanned column: lowest row index wins.
- Keys in non-driven columns are invisible by construction.
- Reset mid-operation (any state): outputs return to reset values on that edge; a pending accept is dropped and no pulse is produced.
- Counter width: $clog2(DEBOUNCE_TICKS+1). Divider width: $clog2(CLK_DIV).

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - Constants KP_ROWS=4, KP_COLS=4, COL_IDLE=4'b1110.
- Sub-module tick_div (parameter CLK_DIV; ports clk, rst_n, tick); reusable by the display driver.
- Synchronizer and FSM live in keypad_scan.

Test Plan (bench uses CLK_DIV=4, DEBOUNCE_TICKS=3):
1. Reset, rows all 1 -> col_out=1110 immediately after reset; then 1101, 1011, 0111, 1110 every 4 clks; key_valid/key_held stay 0.
2. Hold row2 low whenever col1 is driven, for 10 ticks -> exactly one key_valid pulse (1 clk); key_code=4'h9; key_held=1; col_out frozen at 1101.
3. Bounce: row2/col1 low for 2 ticks then released -> no key_valid, key_code unchanged; scanning resumes (col_out advances to 1011 next tick).
4. After case 2: release for 1 tick, press for 1 tick, release for 3 ticks -> no second key_valid; key_held stays 1 until the 3rd released tick, then 0.
5. Rows 1 and 3 both low on col3 -> key_code=4'h7 (row1 wins), one pulse.
6. Assert rst_n=0 during DEBOUNCE count=2 -> next cycle col_out=1110 and all outputs 0; no key_valid after rst_n returns high with rows released.
